rock_wave_gen: RTL
==================

// Module: rock_wave_gen
// PURPOSE
// - Downstream of the amplitude/frequency controller. Consumes its 3-bit A (amplitude) and F (frequency) settings.
// - Generates the cradle-rocking triangle motion as stepper step/dir pulses plus a signed position.
// - A and F are sampled only at the centre crossing (cycle start), so setting changes never cause motion jumps.
// - A==0 or F==0 at a cycle boundary parks the cradle at centre (IDLE).
// PARAMETERS
// - BASE_DIV  1000  clocks per step at F=7; step period = BASE_DIV*(8-F) clocks
// - AMP_STEP  4     position steps per amplitude unit; swing limit L = A*AMP_STEP
// - POS_W     6     signed position width; must hold +/-7*AMP_STEP
// - DIV_W     16    prescaler width; must hold 7*BASE_DIV-1
// PORTS
// - clk         in   1      system clock
// - reset       in   1      asynchronous, active-high reset
// - en          in   1      motion enable from top-level control
// - A           in   3      amplitude setting from controller (0 = stop)
// - F           in   3      frequency setting from controller (0 = stop)
// - pos         out  POS_W  signed cradle position, centre = 0
// - step        out  1      1-clk pulse per motor step
// - dir         out  1      1 = +1 step, 0 = -1 step; valid when step=1
// - busy        out  1      1 in any state other than IDLE
// - cycle_done  out  1      1-clk pulse when a full period ends at centre
// BEHAVIOUR
// - Reset (async, immediate, also mid-motion):
//   - state=IDLE; pos=0; step=0; dir=0; busy=0; cycle_done=0; prescaler=0; latched A/F=0.
// - States: IDLE, OUT (0 -> +L), BACK (+L -> -L), RET (-L -> 0).
// - Prescaler:
//   - DIV = BASE_DIV*(8-F_lat). In OUT/BACK/RET, cnt counts 0..DIV-1.
//   - tick on cnt==DIV-1; cnt wraps to 0. cnt is held 0 in IDLE.
// - Step update: on the tick edge, pos, step and dir update together (registered).
//   - step=1 for exactly that one clock; otherwise step=0.
// - IDLE: if en & A!=0 & F!=0 at an edge -> latch A_lat=A, F_lat=F, cnt=0, go OUT.
//   - The first step follows DIV clocks later.
// - OUT: tick -> pos+1, dir=1; if new pos==+L -> BACK.
// - BACK: tick -> pos-1, dir=0; if new pos==-L -> RET.
// - RET: tick -> pos+1, dir=1; if new pos==0:
//   - pulse cycle_done in the same cycle as that step.
//   - if en & A!=0 & F!=0 (current inputs): relatch A/F, cnt=0, go OUT; else go IDLE.
// - Full period = 4*L*DIV clocks; 4*L steps per period, no dead time between back-to-back cycles.
// - A/F changes mid-cycle: ignored until the next centre crossing.
// - en low mid-cycle: the current period completes to centre, then IDLE (no abrupt stop).
// - busy = (state != IDLE), registered with the state.
// - Arithmetic:
//   - L = A_lat*AMP_STEP, unsigned, zero-extended to POS_W.
//   - pos compared as signed.
//   - pos never exceeds +/-L; no wrap-around is possible with legal parameters.
// TESTING (BASE_DIV=2, AMP_STEP=4)
// - reset mid-BACK at pos=-3 -> next clock pos=0, busy=0, step=0, state IDLE.
// - en=1, A=2, F=6 from IDLE -> L=8, DIV=4.
//   - first step 4 clks after start; pos peaks +8 then -8.
//   - cycle_done after 128 clks; 32 step pulses.
// - A changed 2->5 at pos=+3 in OUT -> current cycle still peaks +/-8; next cycle peaks +/-20.
// - F changed 6->0 mid-cycle -> cycle finishes at pos=0 with cycle_done, then IDLE, busy=0.
// - en dropped at pos=-5 in BACK -> continue to -8, return to 0, then IDLE.
//   - no further steps afterwards.
// - A=7, F=7 -> L=28, DIV=2; pos hits +27 -> +28 -> +27 without overflow; period 224 clks.

Source files
------------

// File: rtl/rock_wave_gen.sv
// Cradle-rocking triangle motion generator: produces stepper step/dir pulses and a signed
// position that swings 0 -> +L -> -L -> 0, with amplitude/frequency resampled only at centre.
module rock_wave_gen #(
    parameter int BASE_DIV = 1000,
    parameter int AMP_STEP = 4,
    parameter int POS_W    = 6,
    parameter int DIV_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [2:0]              A,
    input  logic [2:0]              F,
    output logic signed [POS_W-1:0] pos,
    output logic                    step,
    output logic                    dir,
    output logic                    busy,
    output logic                    cycle_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_BACK = 2'd2,
        ST_RET  = 2'd3
    } state_e;

    localparam logic [DIV_W-1:0] BASE_DIV_C = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE_C  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] AMP_C      = POS_W'(AMP_STEP);
    localparam logic [POS_W-1:0] POS_ONE_C  = {{(POS_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             cycle_done_q, cycle_done_d;
    logic [2:0]       a_lat_q, a_lat_d;
    logic [2:0]       f_lat_q, f_lat_d;

    logic [3:0]       f_span_s;
    logic [DIV_W-1:0] div_last_s;
    logic [POS_W-1:0] limit_s;
    logic [POS_W-1:0] neg_limit_s;
    logic [POS_W-1:0] pos_inc_s;
    logic [POS_W-1:0] pos_dec_s;
    logic             tick_s;
    logic             start_ok_s;

    // Step period and swing limit derived from the settings latched at the last centre crossing
    always_comb begin
        f_span_s    = 4'd8 - {1'b0, f_lat_q};
        div_last_s  = (BASE_DIV_C * {{(DIV_W-4){1'b0}}, f_span_s}) - DIV_ONE_C;
        limit_s     = {{(POS_W-3){1'b0}}, a_lat_q} * AMP_C;
        neg_limit_s = -limit_s;
        pos_inc_s   = pos_q + POS_ONE_C;
        pos_dec_s   = pos_q - POS_ONE_C;
        tick_s      = (state_q != ST_IDLE) && (cnt_q == div_last_s);
        start_ok_s  = en && (A != 3'd0) && (F != 3'd0);
    end

    // Next-state logic: prescaler, position stepping and cycle sequencing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        step_d       = 1'b0;
        dir_d        = dir_q;
        cycle_done_d = 1'b0;
        a_lat_d      = a_lat_q;
        f_lat_d      = f_lat_q;

        if (state_q == ST_IDLE) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (tick_s) begin
            cnt_d  = {DIV_W{1'b0}};
            step_d = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_ONE_C;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    a_lat_d = A;
                    f_lat_d = F;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (tick_s) begin
                    pos_d = pos_inc_s;
                    dir_d = 1'b1;
                    if (pos_inc_s == limit_s) begin
                        state_d = ST_BACK;
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_BACK: begin
                if (tick_s) begin
                    pos_d = pos_dec_s;
                    dir_d = 1'b0;
                    if (pos_dec_s == neg_limit_s) begin
                        state_d = ST_RET;
                    end else begin
                        state_d = ST_BACK;
                    end
                end else begin
                    state_d = ST_BACK;
                end
            end
            ST_RET: begin
                if (tick_s) begin
                    pos_d = pos_inc_s;
                    dir_d = 1'b1;
                    if (pos_inc_s == {POS_W{1'b0}}) begin
                        // Centre crossing: the only point where new settings take effect
                        cycle_done_d = 1'b1;
                        if (start_ok_s) begin
                            a_lat_d = A;
                            f_lat_d = F;
                            state_d = ST_OUT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_RET;
                    end
                end else begin
                    state_d = ST_RET;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = {POS_W{1'b0}};
                cnt_d   = {DIV_W{1'b0}};
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {DIV_W{1'b0}};
            pos_q        <= {POS_W{1'b0}};
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            a_lat_q      <= 3'd0;
            f_lat_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            a_lat_q      <= a_lat_d;
            f_lat_q      <= f_lat_d;
        end
    end

    assign pos        = $signed(pos_q);
    assign step       = step_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;

endmodule
